// File: rtl/hex_scan_ctrl.sv
// Seven-segment display controller: loads a packed hex value and scans it
// through one shared decoder, MSB digit first, with blanking, LZ suppression and blink.

module hex7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

module hex_scan_ctrl #(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NDIGITS-1:0]   load_value,
  input  logic [NDIGITS-1:0]     load_blank,
  input  logic                   lz_suppress,
  input  logic [NDIGITS-1:0]     blink_en,
  output logic                   busy,
  output logic [7*NDIGITS-1:0]   hex
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BLINK_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                    state_q;
  logic                      loadReady_q;
  logic                      busy_q;
  logic [NDIGITS-1:0][3:0]   valShadow_q;
  logic [NDIGITS-1:0]        blankShadow_q;
  logic                      lzShadow_q;
  logic                      leading_q;
  logic [IW-1:0]             idx_q;
  logic [NDIGITS-1:0][6:0]   hexReg_q;
  logic [CW-1:0]             blinkCnt_q;
  logic                      phase_q;

  logic [3:0]                nibble_d;
  logic [6:0]                decSeg;
  logic [6:0]                seg_d;

  hex7seg u_dec (
    .nibble_i (nibble_d),
    .seg_o    (decSeg)
  );

  // A zero digit is blanked only while every digit above it was also zero
  always_comb begin
    nibble_d = valShadow_q[idx_q];
    seg_d    = decSeg;
    if (blankShadow_q[idx_q] ||
        (lzShadow_q && leading_q && (nibble_d == 4'd0) && (idx_q != '0)))
      seg_d = 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      loadReady_q   <= 1'b1;
      busy_q        <= 1'b0;
      hexReg_q      <= {NDIGITS{7'h7F}};
      valShadow_q   <= '0;
      blankShadow_q <= '0;
      lzShadow_q    <= 1'b0;
      leading_q     <= 1'b0;
      idx_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid && loadReady_q) begin
            valShadow_q   <= load_value;
            blankShadow_q <= load_blank;
            lzShadow_q    <= lz_suppress;
            idx_q         <= LAST_IDX;
            leading_q     <= 1'b1;
            state_q       <= SCAN;
            loadReady_q   <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        SCAN: begin
          hexReg_q[idx_q] <= seg_d;
          if (nibble_d != 4'd0)
            leading_q <= 1'b0;
          if (idx_q == '0) begin
            state_q     <= IDLE;
            loadReady_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          loadReady_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Blink timebase free-runs regardless of loads; phase=1 is the dark half
  always_ff @(posedge clk) begin
    if (reset) begin
      blinkCnt_q <= '0;
      phase_q    <= 1'b0;
    end else if (blinkCnt_q == CNT_MAX) begin
      blinkCnt_q <= '0;
      phase_q    <= ~phase_q;
    end else begin
      blinkCnt_q <= blinkCnt_q + 1'b1;
    end
  end

  always_comb begin
    hex = '0;
    for (int i = 0; i < NDIGITS; i++)
      hex[7*i +: 7] = (phase_q && blink_en[i]) ? 7'h7F : hexReg_q[i];
  end

  assign load_ready = loadReady_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: directed cases plus randomized traffic
// compared every cycle against a digit-level behavioural model.

module tb_hex_scan_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [4*ND-1:0] load_value = '0;
  logic [ND-1:0]   load_blank = '0;
  logic            lz_suppress = 1'b0;
  logic [ND-1:0]   blink_en = '0;
  logic            busy;
  logic [7*ND-1:0] hex;

  hex_scan_ctrl #(.NDIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .load_blank  (load_blank),
    .lz_suppress (lz_suppress),
    .blink_en    (blink_en),
    .busy        (busy),
    .hex         (hex)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;
  int cycleNo   = 0;

  logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  bit         modelValid = 1'b0;
  bit         mScanning  = 1'b0;
  bit         mXfer      = 1'b0;
  bit         dutXfer    = 1'b0;
  int         mAge       = 0;
  int         mCyc       = 0;
  logic [6:0] mHex   [ND];
  logic [6:0] mFinal [ND];

  localparam logic [7*ND-1:0] ALL_BLANK = {ND{7'h7F}};

  // Final picture of a load: a zero digit counts as leading when the value shifted
  // down to it is entirely zero
  task automatic computeFinal(input logic [4*ND-1:0] v, input logic [ND-1:0] b, input logic lz);
    logic [4*ND-1:0] top;
    bit lzb;
    for (int k = 0; k < ND; k++) begin
      top = v >> (4 * k);
      lzb = lz && (top == '0) && (k != 0);
      mFinal[k] = (b[k] || lzb) ? 7'h7F : segTable[v[4*k +: 4]];
    end
  endtask

  // Model advance for one rising edge; digit k appears ND-k edges after the transfer
  task automatic modelEdge();
    mXfer = 1'b0;
    if (reset) begin
      modelValid = 1'b1;
      mCyc       = 0;
      mScanning  = 1'b0;
      mAge       = 0;
      for (int k = 0; k < ND; k++) mHex[k] = 7'h7F;
    end else begin
      mCyc++;
      if (mScanning) begin
        mAge++;
        mHex[ND - mAge] = mFinal[ND - mAge];
        if (mAge == ND) mScanning = 1'b0;
      end else if (load_valid) begin
        computeFinal(load_value, load_blank, lz_suppress);
        mScanning = 1'b1;
        mAge      = 0;
        mXfer     = 1'b1;
      end
    end
  endtask

  task automatic checkOne(input string name, input logic [7*ND-1:0] act, input logic [7*ND-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic timeoutFail(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: got timeout, expected completion (cycle %0d)", name, cycleNo);
  endtask

  // Per-cycle comparison of every output against the model
  task automatic checkOutput();
    logic [7*ND-1:0] expHex;
    bit phase;
    if (!modelValid) return;
    phase = ((mCyc / BD) % 2) == 1;
    for (int k = 0; k < ND; k++)
      expHex[7*k +: 7] = (phase && blink_en[k]) ? 7'h7F : mHex[k];
    checkOne("hex", hex, expHex);
    checkOne("busy", 42'(busy), 42'(mScanning));
    checkOne("load_ready", 42'(load_ready), 42'(!mScanning));
  endtask

  task automatic stepCycle();
    dutXfer = load_ready && load_valid;
    @(posedge clk);
    modelEdge();
    cycleNo++;
    #1;
    checkOutput();
  endtask

  // Issues one load, waits for it to finish, returns how many samples showed busy
  task automatic applyStimulus(input logic [4*ND-1:0] v, input logic [ND-1:0] b,
                               input logic lz, output int busyCnt);
    int n;
    load_value  = v;
    load_blank  = b;
    lz_suppress = lz;
    load_valid  = 1'b1;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (!dutXfer && n < 20);
    load_valid = 1'b0;
    if (!dutXfer) timeoutFail("load_accept");
    busyCnt = busy ? 1 : 0;
    n = 0;
    while (busy && n < 20) begin
      stepCycle();
      if (busy) busyCnt++;
      n++;
    end
  endtask

  function automatic logic [4*ND-1:0] randVal();
    logic [4*ND-1:0] v;
    for (int k = 0; k < ND; k++)
      v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v >> (4 * $urandom_range(0, ND));
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bc, first, second, count79, n;

    reset = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    checkOne("reset_hex", hex, ALL_BLANK);
    checkOne("reset_ready", 42'(load_ready), 42'd1);
    checkOne("reset_busy", 42'(busy), 42'd0);

    for (int i = 0; i < 20; i++) stepCycle();
    checkOne("idle_hex", hex, ALL_BLANK);

    applyStimulus(24'h0123AF, '0, 1'b0, bc);
    checkOne("busy_len", 42'(bc), 42'd6);
    checkOne("digits_0123AF", hex, {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E});

    applyStimulus(24'h000050, '0, 1'b1, bc);
    checkOne("lz_000050", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40});
    applyStimulus(24'h000000, '0, 1'b1, bc);
    checkOne("lz_000000", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    load_value  = 24'h888888;
    load_blank  = 6'b000101;
    lz_suppress = 1'b0;
    load_valid  = 1'b1;
    first  = -1;
    second = -1;
    n      = 0;
    while (second < 0 && n < 30) begin
      stepCycle();
      if (dutXfer) begin
        if (first < 0) first = cycleNo;
        else second = cycleNo;
      end
      n++;
    end
    load_valid = 1'b0;
    checkOne("b2b_gap", 42'(second - first), 42'd7);
    checkOne("blank_888888", hex, {7'h00, 7'h00, 7'h00, 7'h7F, 7'h00, 7'h7F});
    for (int i = 0; i < ND; i++) stepCycle();
    checkOne("blank_888888_again", hex, {7'h00, 7'h00, 7'h00, 7'h7F, 7'h00, 7'h7F});

    applyStimulus(24'h000001, '0, 1'b0, bc);
    blink_en = 6'b000001;
    count79  = 0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      if (hex[6:0] == 7'h79) count79++;
      checkOne("blink_others", 42'(hex[7*ND-1:7]), 42'({5{7'h40}}));
    end
    checkOne("blink_on_count", 42'(count79), 42'd4);
    blink_en = '0;

    load_value = 24'hFFFFFF;
    load_blank = '0;
    load_valid = 1'b1;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (!dutXfer && n < 20);
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    checkOne("midscan_digit5", 42'(hex[41:35]), 42'(7'h0E));
    reset = 1'b1;
    stepCycle();
    checkOne("abort_hex", hex, ALL_BLANK);
    checkOne("abort_ready", 42'(load_ready), 42'd1);
    checkOne("abort_busy", 42'(busy), 42'd0);
    reset = 1'b0;
    stepCycle();

    // Randomized traffic: valid held until accepted, live blink mask, sporadic resets
    for (int i = 0; i < 600; i++) begin
      if (!load_valid && $urandom_range(0, 3) == 0) begin
        load_value  = randVal();
        load_blank  = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0;
        lz_suppress = 1'($urandom);
        load_valid  = 1'b1;
      end
      if (i % 5 == 0) blink_en = ND'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      stepCycle();
      if (dutXfer && !reset) load_valid = 1'b0;
    end
    reset = 1'b0;
    stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
